// File: rtl/onewire_slave_pkg.sv
// Shared state encoding, default slot timing and bit-count width for the 1-wire slave.
// Timing defaults assume a 1 MHz clk, so one cycle is one microsecond.
package onewire_slave_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SLOT = 3'd1;
    localparam logic [2:0] S_RSTL = 3'd2;
    localparam logic [2:0] S_PDLY = 3'd3;
    localparam logic [2:0] S_PRES = 3'd4;

    typedef enum logic [2:0] {
        IDLE = S_IDLE,
        SLOT = S_SLOT,
        RSTL = S_RSTL,
        PDLY = S_PDLY,
        PRES = S_PRES
    } state_t;

    localparam int CW_DEF    = 10;
    localparam int T_RST_DEF = 480;
    localparam int T_PDL_DEF = 30;
    localparam int T_PRS_DEF = 120;
    localparam int T_SMP_DEF = 30;
    localparam int T_RD_DEF  = 30;

    localparam int BCW = 3;

endpackage

// File: rtl/onewire_slave_timer.sv
// Slot timer: CW-bit up-counter that sticks at all-ones; clr wins over ena.
// Latency: cnt reflects clr/ena one cycle later. Backpressure: none.
// All threshold compares live in the parent so one timer serves every state.
module onewire_slave_timer #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ena,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ena && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/onewire_slave.sv
// 1-wire slave: bus-reset/presence handling, LSB-first byte receive over write slots and send over read slots.
// Latency: rx_vld/rst_det are registered and assert in the cycle after the qualifying line edge is seen.
// Backpressure: rx has none; tx_rdy only while idle between bytes. ONEWIRE_SLAVE_SYNC_EN adds a 2-flop line synchronizer.
module onewire_slave
    import onewire_slave_pkg::*;
#(
    parameter int CW    = CW_DEF,
    parameter int T_RST = T_RST_DEF,
    parameter int T_PDL = T_PDL_DEF,
    parameter int T_PRS = T_PRS_DEF,
    parameter int T_SMP = T_SMP_DEF,
    parameter int T_RD  = T_RD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       owr_i,
    output logic       owr_e,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    input  logic [7:0] tx_dat,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       rst_det,
    output logic       busy
);

    localparam logic [CW-1:0] C_RST = CW'(T_RST);
    localparam logic [CW-1:0] C_PDL = CW'(T_PDL - 1);
    localparam logic [CW-1:0] C_PRS = CW'(T_PRS - 1);
    localparam logic [CW-1:0] C_SMP = CW'(T_SMP);
    localparam logic [CW-1:0] C_RD  = CW'(T_RD);

    state_t         state, state_nxt;
    logic           ln, ln_q, fall, rise;
    logic [CW-1:0]  cnt;
    logic           tmr_clr, tmr_ena;
    logic           lat, lat_val, slot_end, rst_hit, rdet;
    logic           bit_got;
    logic [BCW-1:0] bcnt;
    logic [7:0]     rx_sh, rx_nxt, tx_sh;
    logic           tx_act;

`ifdef ONEWIRE_SLAVE_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], owr_i};
        end
    end

    assign ln = sync[1];
`else
    assign ln = owr_i;
`endif

    assign fall = ln_q & ~ln;
    assign rise = ~ln_q & ln;

    onewire_slave_timer #(.CW(CW)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .ena (tmr_ena),
        .cnt (cnt)
    );

    assign tmr_ena = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        lat       = 1'b0;
        lat_val   = 1'b0;
        slot_end  = 1'b0;
        rst_hit   = 1'b0;
        rdet      = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = SLOT;
                    tmr_clr   = 1'b1;
                end
            end
            SLOT: begin
                // A write bit is taken once per slot: an early release means 1.
                if (!tx_act && !bit_got) begin
                    if (rise) begin
                        lat     = 1'b1;
                        lat_val = 1'b1;
                    end else if (cnt == C_SMP) begin
                        lat     = 1'b1;
                        lat_val = ln;
                    end
                end
                if (rise) begin
                    state_nxt = IDLE;
                    slot_end  = 1'b1;
                end else if ((cnt == C_RST) && !ln) begin
                    state_nxt = RSTL;
                    rst_hit   = 1'b1;
                end
            end
            RSTL: begin
                if (rise) begin
                    state_nxt = PDLY;
                    tmr_clr   = 1'b1;
                    rdet      = 1'b1;
                end
            end
            PDLY: begin
                // Master pulled low before presence began: treat it as a new slot.
                if (fall) begin
                    state_nxt = SLOT;
                    tmr_clr   = 1'b1;
                end else if (cnt == C_PDL) begin
                    state_nxt = PRES;
                    tmr_clr   = 1'b1;
                end
            end
            PRES: begin
                if (cnt == C_PRS) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rx_nxt = lat ? {lat_val, rx_sh[7:1]} : rx_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            ln_q    <= 1'b1;
            bcnt    <= '0;
            bit_got <= 1'b0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            tx_act  <= 1'b0;
            rx_dat  <= '0;
            rx_vld  <= 1'b0;
            rst_det <= 1'b0;
        end else begin
            ln_q    <= ln;
            rx_vld  <= 1'b0;
            rst_det <= rdet;
            if (lat) begin
                bit_got <= 1'b1;
            end else if (tmr_clr) begin
                bit_got <= 1'b0;
            end
            if (lat) begin
                rx_sh <= rx_nxt;
            end
            if (tx_vld && tx_rdy) begin
                tx_sh  <= tx_dat;
                tx_act <= 1'b1;
            end
            if (slot_end) begin
                bcnt <= bcnt + 1'b1;
                if (tx_act) begin
                    tx_sh <= {1'b0, tx_sh[7:1]};
                end
                if (bcnt == '1) begin
                    if (tx_act) begin
                        tx_act <= 1'b0;
                    end else begin
                        rx_dat <= rx_nxt;
                        rx_vld <= 1'b1;
                    end
                end
            end
            // A bus reset abandons any byte in flight in either direction.
            if (rst_hit) begin
                bcnt   <= '0;
                rx_sh  <= '0;
                tx_act <= 1'b0;
            end
        end
    end

    assign owr_e  = (state == PRES) ||
                    ((state == SLOT) && tx_act && !tx_sh[0] && (cnt < C_RD));
    assign tx_rdy = (state == IDLE) && !tx_act && (bcnt == '0);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: slot-level model marks expected owr_e/rst_det/rx_vld per cycle; a compare process checks every cycle.
module tb_onewire_slave;

    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst, owr_i, owr_e, rx_vld, tx_vld, tx_rdy, rst_det, busy, m_low;
    logic [7:0] rx_dat, tx_dat;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_oe    = 0;
    int n_rd    = 0;
    int n_rv    = 0;
    bit chk_en  = 1'b0;

    bit         exp_oe  [MAXC];
    bit         exp_rd  [MAXC];
    bit         exp_rv  [MAXC];
    logic [7:0] exp_rxd [MAXC];

    // Slot-level model: bit position, byte being received, byte being sent.
    int         m_bits    = 0;
    logic [7:0] m_rx      = 8'h00;
    logic [7:0] m_tx      = 8'h00;
    bit         m_tx_act  = 1'b0;
    bit         m_tx_hold = 1'b0;

    onewire_slave dut (
        .clk     (clk),
        .rst     (rst),
        .owr_i   (owr_i),
        .owr_e   (owr_e),
        .rx_dat  (rx_dat),
        .rx_vld  (rx_vld),
        .tx_dat  (tx_dat),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .rst_det (rst_det),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Open-drain bus: low if either end pulls down.
    assign owr_i = ~(m_low | owr_e);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (chk_en && (cyc < MAXC)) begin
            chk("owr_e", {31'd0, owr_e}, {31'd0, exp_oe[cyc]});
            chk("rst_det", {31'd0, rst_det}, {31'd0, exp_rd[cyc]});
            chk("rx_vld", {31'd0, rx_vld}, {31'd0, exp_rv[cyc]});
            if (exp_rv[cyc]) chk("rx_dat", {24'd0, rx_dat}, {24'd0, exp_rxd[cyc]});
            if (owr_e === 1'b1)   n_oe++;
            if (rst_det === 1'b1) n_rd++;
            if (rx_vld === 1'b1)  n_rv++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master holds the line low for l cycles, then releases; returns one cycle after release.
    task automatic pulse(input int l);
        m_low = 1'b1;
        cyc_wait(l);
        m_low = 1'b0;
        cyc_wait(1);
    endtask

    // One 70-cycle slot; read or write chosen by what the model says the slave is doing.
    task automatic slot(input bit b);
        int f;
        int l;
        bit v;
        f = cyc + 1;
        if (m_tx_act) begin
            v = m_tx[m_bits];
            if (!v) for (int k = 0; k < 30; k++) exp_oe[f + k] = 1'b1;
            m_bits++;
            if (m_bits == 8) begin
                m_bits   = 0;
                m_tx_act = 1'b0;
            end
            pulse(2);
            cyc_wait(67);
        end else begin
            l = b ? 5 : 60;
            m_rx[m_bits] = b;
            m_bits++;
            if (m_bits == 8) begin
                m_bits          = 0;
                exp_rv[f + l]   = 1'b1;
                exp_rxd[f + l]  = m_rx;
            end
            pulse(l);
            if ((m_bits == 0) && m_tx_hold) begin
                chk("tx_rdy_wrap", {31'd0, tx_rdy}, 32'd1);
                cyc_wait(1);
                chk("tx_load", {31'd0, tx_rdy}, 32'd0);
                tx_vld    = 1'b0;
                m_tx_hold = 1'b0;
                m_tx_act  = 1'b1;
                m_tx      = tx_dat;
                cyc_wait(70 - l - 2);
            end else begin
                cyc_wait(70 - l - 1);
            end
        end
    endtask

    // 500-cycle reset low; cut=1 asserts rst at cycle 50 of the presence pulse.
    task automatic bus_reset(input bit cut);
        int r;
        int hi;
        r  = cyc + 1 + 500;
        hi = cut ? r + 79 : r + 149;
        exp_rd[r] = 1'b1;
        for (int k = r + 30; k <= hi; k++) exp_oe[k] = 1'b1;
        m_bits   = 0;
        m_rx     = 8'h00;
        m_tx_act = 1'b0;
        m_low = 1'b1;
        cyc_wait(500);
        m_low = 1'b0;
        if (cut) begin
            cyc_wait(80);
            rst = 1'b1;
            cyc_wait(1);
            chk("t6_owr_e", {31'd0, owr_e}, 32'd0);
            chk("t6_busy", {31'd0, busy}, 32'd0);
            chk("t6_tx_rdy", {31'd0, tx_rdy}, 32'd1);
            chk("t6_rx_dat", {24'd0, rx_dat}, 32'd0);
            rst = 1'b0;
            cyc_wait(20);
        end else begin
            cyc_wait(200);
        end
    endtask

    task automatic read_byte(output logic [7:0] mask);
        int n0;
        for (int i = 0; i < 8; i++) begin
            n0 = n_oe;
            slot(1'b1);
            mask[i] = ((n_oe - n0) == 30);
        end
    endtask

    initial begin
        logic [7:0] wbyte;
        logic [7:0] mask;
        int         rd0, oe0, rv0;

        rst    = 1'b1;
        m_low  = 1'b0;
        tx_vld = 1'b0;
        tx_dat = 8'h00;
        cyc_wait(3);
        chk("rst_owr_e", {31'd0, owr_e}, 32'd0);
        chk("rst_rx_vld", {31'd0, rx_vld}, 32'd0);
        chk("rst_rst_det", {31'd0, rst_det}, 32'd0);
        chk("rst_rx_dat", {24'd0, rx_dat}, 32'd0);
        chk("rst_tx_rdy", {31'd0, tx_rdy}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        cyc_wait(5);

        // 1: bus reset and presence
        rd0 = n_rd; oe0 = n_oe;
        bus_reset(1'b0);
        chk("t1_rst_det_cnt", n_rd - rd0, 32'd1);
        chk("t1_pres_len", n_oe - oe0, 32'd120);

        // 2: receive 0xA5
        rv0 = n_rv;
        wbyte = 8'hA5;
        for (int i = 0; i < 8; i++) slot(wbyte[i]);
        chk("t2_rx_dat", {24'd0, rx_dat}, 32'hA5);
        chk("t2_rx_vld_cnt", n_rv - rv0, 32'd1);

        // 3: send 0x3C
        rv0 = n_rv;
        tx_dat = 8'h3C;
        tx_vld = 1'b1;
        chk("t3_tx_rdy_idle", {31'd0, tx_rdy}, 32'd1);
        cyc_wait(1);
        chk("t3_tx_rdy_loaded", {31'd0, tx_rdy}, 32'd0);
        tx_vld   = 1'b0;
        m_tx_act = 1'b1;
        m_tx     = 8'h3C;
        read_byte(mask);
        chk("t3_drive_mask", {24'd0, mask}, 32'hC3);
        chk("t3_tx_rdy_done", {31'd0, tx_rdy}, 32'd1);
        chk("t3_no_rx_vld", n_rv - rv0, 32'd0);

        // 4: partial write cut by bus reset, then 0xFF
        rv0 = n_rv; rd0 = n_rd;
        slot(1'b1); slot(1'b0); slot(1'b1);
        bus_reset(1'b0);
        chk("t4_no_rx_vld", n_rv - rv0, 32'd0);
        chk("t4_rst_det_cnt", n_rd - rd0, 32'd1);
        rv0 = n_rv;
        for (int i = 0; i < 8; i++) slot(1'b1);
        chk("t4_rx_dat", {24'd0, rx_dat}, 32'hFF);
        chk("t4_rx_vld_cnt", n_rv - rv0, 32'd1);

        // 5: tx offered mid-byte waits for the byte boundary
        wbyte = 8'h96;
        slot(wbyte[0]);
        slot(wbyte[1]);
        tx_dat    = 8'h5A;
        tx_vld    = 1'b1;
        m_tx_hold = 1'b1;
        cyc_wait(2);
        chk("t5_tx_rdy_mid", {31'd0, tx_rdy}, 32'd0);
        for (int i = 2; i < 8; i++) slot(wbyte[i]);
        chk("t5_rx_dat", {24'd0, rx_dat}, 32'h96);
        read_byte(mask);
        chk("t5_drive_mask", {24'd0, mask}, 32'hA5);

        // 6: rst during presence
        bus_reset(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
